upcnt_ctrl: RTL and testbench
=============================

Name: upcnt_ctrl

Overview:
- Run/stop/clear controller for the 14-bit 10 Hz stopwatch counter (run-enable and clear-request inputs).
- Merges two command sources: debounced push-button pulses and UART receive bytes.
- Sequences run/stop/clear through a small FSM and sends a one-byte acknowledge for every received UART byte through the UART transmitter handshake.
- Sits between the UART/button front end and the counter in the stopwatch top level.

Parameters:
CLR_CYCLES, 2, number of cycles o_clr_on is held high per clear (>=1)
CMD_RUN, 8'h72, UART byte 'r' = run
CMD_STOP, 8'h73, UART byte 's' = stop
CMD_CLR, 8'h63, UART byte 'c' = clear
ACK_REJ, 8'h21, reply '!' when a command is valid but not allowed in the current state
ACK_UNK, 8'h3F, reply '?' for an unrecognised byte

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset; block held in reset while 0
i_btn_run  in  1  1-cycle pulse, debounced upstream; toggles run/stop
i_btn_clr  in  1  1-cycle pulse, debounced upstream; clear request
i_rx_valid  in  1  1-cycle strobe; i_rx_data is valid
i_rx_data  in  8  received UART byte
i_tx_busy  in  1  UART transmitter busy
o_tx_start  out  1  1-cycle pulse to start transmitting o_tx_data
o_tx_data  out  8  acknowledge byte; stable from the start pulse until busy falls
o_run_on  out  1  counter run enable
o_clr_on  out  1  counter clear request
o_state  out  2  current FSM state (debug/LED)
o_ack_drop  out  1  1-cycle pulse: ack discarded because the pending slot was full

Behaviour:
- Reset (reset=0, asynchronous): state=STOP; o_run_on=0, o_clr_on=0, o_state=0, o_tx_start=0, o_tx_data=0, o_ack_drop=0; ack slot empty; tx FSM=TX_IDLE.
- Events decoded combinationally each cycle:
  - ev_clr = i_btn_clr | (i_rx_valid & data==CMD_CLR)
  - ev_run = i_rx_valid & data==CMD_RUN
  - ev_stop = i_rx_valid & data==CMD_STOP
  - ev_tog = i_btn_run
- FSM states and encodings: STOP=0, RUN=1, CLEAR=2.
  - STOP: ev_clr -> CLEAR (clear wins over run/toggle in the same cycle); else ev_run|ev_tog -> RUN; else stay.
  - RUN: ev_stop|ev_tog -> STOP; ev_run -> stay; ev_clr rejected (no state change).
  - CLEAR: a down-counter is loaded with CLR_CYCLES-1 on entry. Exit to STOP when the counter reaches 0. All events in CLEAR are rejected.
- Outputs are registered:
  - o_run_on = (state==RUN); o_clr_on = (state==CLEAR); o_state = state.
  - Latency: an event in cycle n is reflected on the outputs in cycle n+1.
  - o_run_on and o_clr_on are never both 1.
  - o_clr_on is high for exactly CLR_CYCLES consecutive cycles per clear.
- Ack generation: every i_rx_valid produces exactly one ack candidate.
  - The command byte itself is echoed if accepted.
  - ACK_REJ if the byte is a recognised command that is rejected in the current state.
  - ACK_UNK if the byte is not a recognised command.
  - 'r' in RUN and 's' in STOP are accepted (echoed), with no state change.
- Ack slot is 1 deep.
  - If the candidate arrives while the slot is full and the slot is not being emptied in the same cycle, the candidate is discarded and o_ack_drop pulses.
  - Write and empty in the same cycle: the new candidate is stored.
- TX handshake FSM:
  - TX_IDLE: slot full & !i_tx_busy -> o_tx_start=1 for 1 cycle, o_tx_data=slot, slot emptied -> TX_WAIT_BUSY.
  - TX_WAIT_BUSY: wait for i_tx_busy=1 -> TX_WAIT_DONE.
  - TX_WAIT_DONE: wait for i_tx_busy=0 -> TX_IDLE.
  - No new start is issued outside TX_IDLE. o_tx_data holds its value until the next start.
- Button events never generate acks.
- Reset asserted mid-clear or mid-transmit: all state is abandoned immediately; no start pulse after reset is released until a new rx byte arrives.

Decomposition:
- Package upcnt_ctrl_pkg holds:
  - the state encodings (STOP/RUN/CLEAR, TX_IDLE/TX_WAIT_BUSY/TX_WAIT_DONE);
  - the default command and ack byte constants.
- One sub-module, upcnt_ack_tx, contains the 1-deep ack slot, the drop logic and the tx handshake FSM.
- The top level contains the event decode, the main FSM and the clear down-counter.

Test Plan:
- Release reset; pulse i_btn_run -> o_run_on=1 next cycle, o_state=1; pulse again -> o_run_on=0, o_state=0.
- In STOP, send rx 8'h63 -> o_clr_on=1 for exactly 2 cycles, then o_state=0; o_tx_start pulses with o_tx_data=8'h63.
- In RUN, send rx 8'h63 -> state stays RUN, o_clr_on stays 0, ack o_tx_data=8'h21; send 8'h41 -> ack 8'h3F.
- In STOP, same cycle i_btn_clr=1 and rx 8'h72 -> enters CLEAR (not RUN); ack 8'h21.
- Hold i_tx_busy=1; send three rx bytes back to back -> first ack stored, 2nd and 3rd produce o_ack_drop pulses; after busy falls exactly one o_tx_start.
- Assert reset=0 during the CLEAR hold and during TX_WAIT_DONE -> all outputs 0 immediately; after release no o_tx_start without new rx.

Source files
------------

// File: rtl/upcnt_ctrl_pkg.sv
// upcnt_ctrl_pkg: state encodings and default command/ack bytes for the stopwatch controller
package upcnt_ctrl_pkg;
  typedef enum logic [1:0] {ST_STOP = 2'd0, ST_RUN = 2'd1, ST_CLEAR = 2'd2} state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_WAIT_BUSY = 2'd1, TX_WAIT_DONE = 2'd2} tx_state_t;
  localparam logic [7:0] CMD_RUN_DEF  = 8'h72;
  localparam logic [7:0] CMD_STOP_DEF = 8'h73;
  localparam logic [7:0] CMD_CLR_DEF  = 8'h63;
  localparam logic [7:0] ACK_REJ_DEF  = 8'h21;
  localparam logic [7:0] ACK_UNK_DEF  = 8'h3F;
endpackage

// File: rtl/upcnt_ack_tx.sv
// upcnt_ack_tx: 1-deep acknowledge slot with overflow drop and UART transmitter start/busy handshake
module upcnt_ack_tx
  import upcnt_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ack_valid,
  input  logic [7:0] i_ack_data,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_ack_drop
);
  tx_state_t  tx_q, tx_d;
  logic       full_q, full_d, start_q, start_d, drop_q, drop_d, send;
  logic [7:0] slot_q, slot_d, data_q, data_d;
  assign send = tx_q == TX_IDLE && full_q && !i_tx_busy;
  // a slot being emptied this cycle can accept a new candidate without dropping it
  always_comb begin
    tx_d    = send ? TX_WAIT_BUSY :
              (tx_q == TX_WAIT_BUSY && i_tx_busy) ? TX_WAIT_DONE :
              (tx_q == TX_WAIT_DONE && !i_tx_busy) ? TX_IDLE : tx_q;
    full_d  = i_ack_valid || (full_q && !send);
    slot_d  = (i_ack_valid && (!full_q || send)) ? i_ack_data : slot_q;
    drop_d  = i_ack_valid && full_q && !send;
    start_d = send;
    data_d  = send ? slot_q : data_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q    <= TX_IDLE;
      full_q  <= 1'b0;
      slot_q  <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      full_q  <= full_d;
      slot_q  <= slot_d;
      start_q <= start_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_ack_drop = drop_q;
endmodule

// File: rtl/upcnt_ctrl.sv
// upcnt_ctrl: run/stop/clear controller for the stopwatch counter, driven by buttons and UART bytes
module upcnt_ctrl
  import upcnt_ctrl_pkg::*;
#(
  parameter int         CLR_CYCLES = 2,
  parameter logic [7:0] CMD_RUN    = CMD_RUN_DEF,
  parameter logic [7:0] CMD_STOP   = CMD_STOP_DEF,
  parameter logic [7:0] CMD_CLR    = CMD_CLR_DEF,
  parameter logic [7:0] ACK_REJ    = ACK_REJ_DEF,
  parameter logic [7:0] ACK_UNK    = ACK_UNK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run,
  input  logic       i_btn_clr,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_run_on,
  output logic       o_clr_on,
  output logic [1:0] o_state,
  output logic       o_ack_drop
);
  localparam int CW = CLR_CYCLES > 1 ? $clog2(CLR_CYCLES) : 1;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cmd_run, cmd_stop, cmd_clr, ev_clr, rej;
  logic [7:0]    ack_data;
  assign cmd_run  = i_rx_valid && i_rx_data == CMD_RUN;
  assign cmd_stop = i_rx_valid && i_rx_data == CMD_STOP;
  assign cmd_clr  = i_rx_valid && i_rx_data == CMD_CLR;
  assign ev_clr   = i_btn_clr || cmd_clr;
  // 'r' loses to a simultaneous button clear in STOP, so it is answered as rejected
  assign rej      = state_q == ST_CLEAR || (state_q == ST_RUN && cmd_clr) ||
                    (state_q == ST_STOP && cmd_run && i_btn_clr);
  assign ack_data = !(cmd_run || cmd_stop || cmd_clr) ? ACK_UNK : rej ? ACK_REJ : i_rx_data;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STOP: begin
        if (ev_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = CW'(CLR_CYCLES - 1);
        end else if (cmd_run || i_btn_run) state_d = ST_RUN;
      end
      ST_RUN:   if (cmd_stop || i_btn_run) state_d = ST_STOP;
      ST_CLEAR: if (cnt_q == '0) state_d = ST_STOP; else cnt_d = cnt_q - 1'b1;
      default:  state_d = ST_STOP;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_run_on = state_q == ST_RUN;
  assign o_clr_on = state_q == ST_CLEAR;
  assign o_state  = state_q;
  upcnt_ack_tx u_ack_tx (
    .clk        (clk),
    .reset      (reset),
    .i_ack_valid(i_rx_valid),
    .i_ack_data (ack_data),
    .i_tx_busy  (i_tx_busy),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_ack_drop (o_ack_drop)
  );
endmodule

// File: tb/tb_upcnt_ctrl.sv
// tb_upcnt_ctrl: directed and randomized checks of upcnt_ctrl against a behavioural model
module tb_upcnt_ctrl;
  localparam int CLR_CYCLES = 2;
  logic       clk = 0, reset = 0;
  logic       i_btn_run = 0, i_btn_clr = 0, i_rx_valid = 0, i_tx_busy = 0;
  logic [7:0] i_rx_data = 0;
  logic       o_tx_start, o_run_on, o_clr_on, o_ack_drop;
  logic [7:0] o_tx_data;
  logic [1:0] o_state;
  int         checks = 0, errors = 0, drops = 0, bcnt = 0;
  bit         auto_tx = 1;
  logic [7:0] got[$], exp_q[$];
  int         m_state = 0, m_left = 0;

  upcnt_ctrl #(.CLR_CYCLES(CLR_CYCLES)) dut (
    .clk(clk), .reset(reset), .i_btn_run(i_btn_run), .i_btn_clr(i_btn_clr),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .i_tx_busy(i_tx_busy),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_run_on(o_run_on),
    .o_clr_on(o_clr_on), .o_state(o_state), .o_ack_drop(o_ack_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] a, logic [15:0] e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, a, e);
    end
  endtask

  // one clock; also plays the UART transmitter and logs starts/drops
  task automatic tick();
    @(posedge clk);
    #1;
    if (o_tx_start) begin
      got.push_back(o_tx_data);
      if (auto_tx) bcnt = 3;
    end
    if (o_ack_drop) drops++;
    if (auto_tx) begin
      i_tx_busy = bcnt > 0;
      if (bcnt > 0) bcnt--;
    end
  endtask

  task automatic rx(logic [7:0] d);
    i_rx_valid = 1;
    i_rx_data  = d;
    tick();
    i_rx_valid = 0;
  endtask

  task automatic wait_ack(string tag, logic [7:0] e);
    int n = 0;
    while (got.size() == 0 && n < 30) begin
      tick();
      n++;
    end
    if (got.size() == 0) chk({tag, "_timeout"}, 16'd1, 16'd0);
    else begin
      logic [7:0] a = got.pop_front();
      chk(tag, {8'd0, a}, {8'd0, e});
    end
  endtask

  task automatic chk_rst(string tag);
    chk(tag, {2'b0, o_run_on, o_clr_on, o_state, o_tx_start, o_tx_data, o_ack_drop}, 16'd0);
  endtask

  function automatic logic [7:0] model_ack(int st, bit bclr, logic [7:0] d);
    bit known = d == 8'h72 || d == 8'h73 || d == 8'h63;
    bit ok = st != 2 && ((d == 8'h72 && !(st == 0 && bclr)) || d == 8'h73 || (d == 8'h63 && st == 0));
    return !known ? 8'h3F : ok ? d : 8'h21;
  endfunction

  initial begin
    repeat (3) tick();
    chk_rst("reset_outs");
    reset = 1;
    tick();
    chk("post_reset_state", {14'd0, o_state}, 16'd0);
    i_btn_run = 1; tick(); i_btn_run = 0;
    chk("tog_run_on", {15'd0, o_run_on}, 16'd1);
    chk("tog_state_run", {14'd0, o_state}, 16'd1);
    i_btn_run = 1; tick(); i_btn_run = 0;
    chk("tog_run_off", {15'd0, o_run_on}, 16'd0);
    chk("tog_state_stop", {14'd0, o_state}, 16'd0);
    rx(8'h63);
    chk("clr_on_1", {15'd0, o_clr_on}, 16'd1);
    chk("clr_state", {14'd0, o_state}, 16'd2);
    tick();
    chk("clr_on_2", {15'd0, o_clr_on}, 16'd1);
    tick();
    chk("clr_on_end", {15'd0, o_clr_on}, 16'd0);
    chk("clr_exit_state", {14'd0, o_state}, 16'd0);
    wait_ack("ack_clr_echo", 8'h63);
    repeat (8) tick();
    i_btn_run = 1; tick(); i_btn_run = 0;
    rx(8'h63);
    chk("run_clr_rej_state", {14'd0, o_state}, 16'd1);
    chk("run_clr_rej_clr", {15'd0, o_clr_on}, 16'd0);
    wait_ack("ack_rej", 8'h21);
    repeat (8) tick();
    rx(8'h41);
    wait_ack("ack_unk", 8'h3F);
    repeat (8) tick();
    i_btn_run = 1; tick(); i_btn_run = 0;
    chk("back_to_stop", {14'd0, o_state}, 16'd0);
    i_btn_clr = 1; rx(8'h72); i_btn_clr = 0;
    chk("clr_beats_run", {14'd0, o_state}, 16'd2);
    chk("clr_beats_run_off", {15'd0, o_run_on}, 16'd0);
    wait_ack("ack_run_rej", 8'h21);
    repeat (8) tick();
    // slot overflow while the transmitter is held busy
    auto_tx = 0; i_tx_busy = 1; drops = 0; got.delete();
    rx(8'h73); rx(8'h41); rx(8'h42);
    repeat (2) tick();
    chk("drop_count", 16'(drops), 16'd2);
    chk("no_start_busy", 16'(got.size()), 16'd0);
    i_tx_busy = 0; auto_tx = 1; bcnt = 0;
    repeat (15) tick();
    chk("one_start_after_busy", 16'(got.size()), 16'd1);
    if (got.size() > 0) chk("kept_ack", {8'd0, got[0]}, 16'h73);
    got.delete();
    rx(8'h63);
    chk("mid_clear_state", {14'd0, o_state}, 16'd2);
    reset = 0; #1;
    chk_rst("rst_mid_clear");
    repeat (2) tick();
    reset = 1;
    repeat (12) tick();
    chk("no_start_after_clr_rst", 16'(got.size()), 16'd0);
    chk("state_after_clr_rst", {14'd0, o_state}, 16'd0);
    auto_tx = 0; i_tx_busy = 0;
    rx(8'h41);
    wait_ack("tx_before_rst", 8'h3F);
    i_tx_busy = 1; tick(); tick();
    rx(8'h42);
    got.delete();
    reset = 0; #1;
    chk_rst("rst_mid_tx");
    i_tx_busy = 0;
    tick();
    reset = 1;
    repeat (12) tick();
    chk("no_start_after_tx_rst", 16'(got.size()), 16'd0);
    // randomized run against the behavioural model
    auto_tx = 1; bcnt = 0; drops = 0; got.delete(); exp_q.delete();
    m_state = 0; m_left = 0;
    for (int r = 0; r < 250; r++) begin
      for (int k = 0; k < 10; k++) begin
        bit br = $urandom_range(7) == 0, bc = $urandom_range(15) == 0, v = k == 9;
        int sel = $urandom_range(3);
        logic [7:0] d = sel == 0 ? 8'h72 : sel == 1 ? 8'h73 : sel == 2 ? 8'h63 : 8'($urandom);
        if (v) exp_q.push_back(model_ack(m_state, bc, d));
        if (m_state == 2) begin
          m_left--;
          if (m_left == 0) m_state = 0;
        end else if (m_state == 0) begin
          if (bc || (v && d == 8'h63)) begin
            m_state = 2;
            m_left = CLR_CYCLES;
          end else if (br || (v && d == 8'h72)) m_state = 1;
        end else if (br || (v && d == 8'h73)) m_state = 0;
        i_btn_run = br; i_btn_clr = bc; i_rx_valid = v; i_rx_data = d;
        tick();
        chk("rnd_state", {14'd0, o_state}, 16'(m_state));
        chk("rnd_run_on", {15'd0, o_run_on}, {15'd0, m_state == 1});
        chk("rnd_clr_on", {15'd0, o_clr_on}, {15'd0, m_state == 2});
      end
    end
    i_btn_run = 0; i_btn_clr = 0; i_rx_valid = 0;
    repeat (15) tick();
    chk("rnd_ack_count", 16'(got.size()), 16'(exp_q.size()));
    chk("rnd_no_drops", 16'(drops), 16'd0);
    while (got.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] a = got.pop_front(), e = exp_q.pop_front();
      chk("rnd_ack", {8'd0, a}, {8'd0, e});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
